// File: rtl/key_pkg.sv
// Shared types and constants for the key conditioning front-end.
package key_pkg;

  // Repeat state machine encoding
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } rep_state_t;

  // Default cycle counts for the 50 MHz board clock
  localparam int DEF_NUM_KEYS            = 4;
  localparam int DEF_DEBOUNCE_CYCLES     = 500000;    // 10 ms
  localparam int DEF_REPEAT_DELAY_CYCLES = 25000000;  // 500 ms
  localparam int DEF_REPEAT_RATE_CYCLES  = 5000000;   // 100 ms

  // Bits needed to hold values 0..max_val (never less than 1)
  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/key_channel.sv
// One key channel: two-flop synchroniser, debouncer, press/release pulses
// and, when KEY_REPEAT_EN is defined, the auto-repeat state machine.
// Without KEY_REPEAT_EN the repeat output simply mirrors the press pulse.
module key_channel
  import key_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES     = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY_CYCLES = DEF_REPEAT_DELAY_CYCLES,
  parameter int REPEAT_RATE_CYCLES  = DEF_REPEAT_RATE_CYCLES,
  parameter int ACTIVE_LOW          = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_key_raw,
  output logic o_level,
  output logic o_press,
  output logic o_release,
  output logic o_repeat,
  output logic o_press_nxt
);

  localparam int DB_W = cnt_w(DEBOUNCE_CYCLES);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic PIN_IDLE = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

  if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY_CYCLES < 1 || REPEAT_RATE_CYCLES < 1) begin : g_bad_cfg
    $error("key_channel: cycle parameters must be >= 1");
  end

  logic            r_sync1;
  logic            r_sync2;
  logic [DB_W-1:0] r_db_cnt;
  logic            r_level;
  logic            r_press;
  logic            r_release;
  logic            w_s;
  logic            w_flip;
  logic            w_rise;
  logic            w_fall;

  // Pressed = 1 internally, inversion applied after the second flop
  assign w_s    = (ACTIVE_LOW != 0) ? ~r_sync2 : r_sync2;
  assign w_flip = (w_s != r_level) && (r_db_cnt == DB_LAST);
  assign w_rise = w_flip & ~r_level;
  assign w_fall = w_flip & r_level;

  // Two-flop synchroniser, reset to the released pin level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= PIN_IDLE;
      r_sync2 <= PIN_IDLE;
    end else begin
      r_sync1 <= i_key_raw;
      r_sync2 <= r_sync1;
    end
  end

  // Debounce: accept a level once it has differed for DEBOUNCE_CYCLES edges
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_db_cnt  <= '0;
      r_level   <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      if (w_s == r_level) begin
        r_db_cnt <= '0;
      end else if (w_flip) begin
        r_db_cnt <= '0;
        r_level  <= ~r_level;
      end else begin
        r_db_cnt <= r_db_cnt + 1'b1;
      end
      r_press   <= w_rise;
      r_release <= w_fall;
    end
  end

  assign o_level     = r_level;
  assign o_press     = r_press;
  assign o_release   = r_release;
  assign o_press_nxt = w_rise;

`ifdef KEY_REPEAT_EN
  localparam int RP_MAX = (REPEAT_DELAY_CYCLES > REPEAT_RATE_CYCLES) ?
                          REPEAT_DELAY_CYCLES : REPEAT_RATE_CYCLES;
  localparam int RP_W = cnt_w(RP_MAX);
  localparam logic [RP_W-1:0] RP_DLY_LAST  = RP_W'(REPEAT_DELAY_CYCLES - 1);
  localparam logic [RP_W-1:0] RP_RATE_LAST = RP_W'(REPEAT_RATE_CYCLES - 1);

  rep_state_t      r_state;
  rep_state_t      w_state_nxt;
  logic [RP_W-1:0] r_rp_cnt;
  logic [RP_W-1:0] w_rp_cnt_nxt;
  logic            r_repeat;
  logic            w_repeat_nxt;

  // Repeat state, counter and registered pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_rp_cnt <= '0;
      r_repeat <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_rp_cnt <= w_rp_cnt_nxt;
      r_repeat <= w_repeat_nxt;
    end
  end

  // Next state: a release on the same edge as an expiry suppresses the pulse
  always_comb begin
    w_state_nxt  = r_state;
    w_rp_cnt_nxt = r_rp_cnt;
    w_repeat_nxt = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_rise) begin
          w_repeat_nxt = 1'b1;
          w_rp_cnt_nxt = '0;
          w_state_nxt  = DELAY;
        end
      end
      DELAY: begin
        if (w_fall) begin
          w_rp_cnt_nxt = '0;
          w_state_nxt  = IDLE;
        end else if (r_rp_cnt == RP_DLY_LAST) begin
          w_repeat_nxt = 1'b1;
          w_rp_cnt_nxt = '0;
          w_state_nxt  = REPEAT;
        end else begin
          w_rp_cnt_nxt = r_rp_cnt + 1'b1;
        end
      end
      REPEAT: begin
        if (w_fall) begin
          w_rp_cnt_nxt = '0;
          w_state_nxt  = IDLE;
        end else if (r_rp_cnt == RP_RATE_LAST) begin
          w_repeat_nxt = 1'b1;
          w_rp_cnt_nxt = '0;
        end else begin
          w_rp_cnt_nxt = r_rp_cnt + 1'b1;
        end
      end
      default: begin
        w_rp_cnt_nxt = '0;
        w_state_nxt  = IDLE;
      end
    endcase
  end

  assign o_repeat = r_repeat;
`else
  assign o_repeat = r_press;
`endif

endmodule

// File: rtl/key_conditioner.sv
// Multi-channel push-button front-end: NUM_KEYS independent key_channel
// instances plus a registered any-key-pressed flag. Auto-repeat is built
// only when KEY_REPEAT_EN is defined.
module key_conditioner
  import key_pkg::*;
#(
  parameter int NUM_KEYS            = DEF_NUM_KEYS,
  parameter int DEBOUNCE_CYCLES     = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY_CYCLES = DEF_REPEAT_DELAY_CYCLES,
  parameter int REPEAT_RATE_CYCLES  = DEF_REPEAT_RATE_CYCLES,
  parameter int ACTIVE_LOW          = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_KEYS-1:0] key_raw,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic [NUM_KEYS-1:0] key_repeat,
  output logic                key_any
);

  logic [NUM_KEYS-1:0] w_press_nxt;
  logic                r_any;

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_ch
    key_channel #(
      .DEBOUNCE_CYCLES    (DEBOUNCE_CYCLES),
      .REPEAT_DELAY_CYCLES(REPEAT_DELAY_CYCLES),
      .REPEAT_RATE_CYCLES (REPEAT_RATE_CYCLES),
      .ACTIVE_LOW         (ACTIVE_LOW)
    ) u_ch (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_key_raw  (key_raw[g]),
      .o_level    (key_level[g]),
      .o_press    (key_press[g]),
      .o_release  (key_release[g]),
      .o_repeat   (key_repeat[g]),
      .o_press_nxt(w_press_nxt[g])
    );
  end

  // Any-press flag registered on the same edge as the press pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_any <= 1'b0;
    end else begin
      r_any <= |w_press_nxt;
    end
  end

  assign key_any = r_any;

endmodule
